// File: rtl/banco_de_registradores_2l1e_pkg.sv
// Shared types and default geometry for the two-read/one-write register bank.
package pkg_banco;

  typedef enum logic [0:0] {
    LIMPANDO = 1'b0,
    PRONTO   = 1'b1
  } estado_t;

  localparam int LARGURA_PADRAO      = 32;
  localparam int PROFUNDIDADE_PADRAO = 8;

endpackage

// File: rtl/banco_de_registradores_2l1e_porta_leitura.sv
// One read port: zero/range masking, write-first bypass and the registered
// dado_lido/valido outputs.
module porta_leitura_banco #(
  parameter int LARGURA      = 32,
  parameter int PROFUNDIDADE = 8,
  parameter int ZERO_FIXO    = 1,
  parameter int AW           = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ativo,
  input  logic               leitura,
  input  logic [AW-1:0]      reg_num,
  input  logic [LARGURA-1:0] dado_armazenado,
  input  logic               escrita_efetiva,
  input  logic [AW-1:0]      reg_escrita,
  input  logic [LARGURA-1:0] dado_escrito,
  output logic [LARGURA-1:0] dado_lido,
  output logic               valido
);

  logic [LARGURA-1:0] dado_sel;
  logic [LARGURA-1:0] dado_lido_d, dado_lido_q;
  logic               valido_d, valido_q;
  logic               leitura_aceita;

  always_comb begin
    dado_sel = dado_armazenado;
    if ((ZERO_FIXO != 0) && (reg_num == '0)) begin
      dado_sel = '0;
    end else if (int'(reg_num) >= PROFUNDIDADE) begin
      dado_sel = '0;
    end else if (escrita_efetiva && (reg_escrita == reg_num)) begin
      dado_sel = dado_escrito;
    end
  end

  always_comb begin
    leitura_aceita = ativo && leitura;
    valido_d       = leitura_aceita;
    dado_lido_d    = dado_lido_q;
    if (leitura_aceita) begin
      dado_lido_d = dado_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dado_lido_q <= '0;
      valido_q    <= 1'b0;
    end else begin
      dado_lido_q <= dado_lido_d;
      valido_q    <= valido_d;
    end
  end

  assign dado_lido = dado_lido_q;
  assign valido    = valido_q;

endmodule

// File: rtl/banco_de_registradores_2l1e.sv
// Register bank, one write port and two read ports, with a sequenced clear
// after reset and an optional hardwired-zero register 0.
module banco_de_registradores_2l1e
  import pkg_banco::*;
#(
  parameter int  LARGURA      = LARGURA_PADRAO,
  parameter int  PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter int  ZERO_FIXO    = 1,
  localparam int AW           = $clog2(PROFUNDIDADE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               escrita,
  input  logic [AW-1:0]      reg_escrita,
  input  logic [LARGURA-1:0] dado_escrito,
  input  logic               leitura_a,
  input  logic [AW-1:0]      reg_a,
  output logic [LARGURA-1:0] dado_lido_a,
  output logic               valido_a,
  input  logic               leitura_b,
  input  logic [AW-1:0]      reg_b,
  output logic [LARGURA-1:0] dado_lido_b,
  output logic               valido_b,
  output logic               ocupado
);

  logic [LARGURA-1:0] registrador_q [PROFUNDIDADE];

  estado_t       estado_d, estado_q;
  logic [AW-1:0] cnt_d, cnt_q;
  logic          ocupado_d, ocupado_q;

  logic               ativo;
  logic               escrita_efetiva;
  logic               wr_en;
  logic [AW-1:0]      wr_idx;
  logic [LARGURA-1:0] wr_dado;
  logic [AW-1:0]      idx_a, idx_b;

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    ocupado_d = ocupado_q;
    case (estado_q)
      LIMPANDO: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(PROFUNDIDADE - 1)) begin
          estado_d  = PRONTO;
          ocupado_d = 1'b0;
          cnt_d     = '0;
        end
      end
      PRONTO: begin
        estado_d = PRONTO;
      end
      default: begin
        estado_d = LIMPANDO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= LIMPANDO;
      cnt_q     <= '0;
      ocupado_q <= 1'b1;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign ocupado = ocupado_q;
  assign ativo   = (estado_q == PRONTO) && !rst;

  // A dropped write (out of range or hardwired zero) must not feed the bypass.
  assign escrita_efetiva = ativo && escrita
                           && (int'(reg_escrita) < PROFUNDIDADE)
                           && !((ZERO_FIXO != 0) && (reg_escrita == '0));

  // Clear sequence and normal writes share the single array write port.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = reg_escrita;
    wr_dado = dado_escrito;
    if (!rst && (estado_q == LIMPANDO)) begin
      wr_en   = 1'b1;
      wr_idx  = cnt_q;
      wr_dado = '0;
    end else if (escrita_efetiva) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      registrador_q[wr_idx] <= wr_dado;
    end
  end

  assign idx_a = (int'(reg_a) < PROFUNDIDADE) ? reg_a : '0;
  assign idx_b = (int'(reg_b) < PROFUNDIDADE) ? reg_b : '0;

  porta_leitura_banco #(
    .LARGURA      (LARGURA),
    .PROFUNDIDADE (PROFUNDIDADE),
    .ZERO_FIXO    (ZERO_FIXO),
    .AW           (AW)
  ) u_porta_a (
    .clk             (clk),
    .rst             (rst),
    .ativo           (ativo),
    .leitura         (leitura_a),
    .reg_num         (reg_a),
    .dado_armazenado (registrador_q[idx_a]),
    .escrita_efetiva (escrita_efetiva),
    .reg_escrita     (reg_escrita),
    .dado_escrito    (dado_escrito),
    .dado_lido       (dado_lido_a),
    .valido          (valido_a)
  );

  porta_leitura_banco #(
    .LARGURA      (LARGURA),
    .PROFUNDIDADE (PROFUNDIDADE),
    .ZERO_FIXO    (ZERO_FIXO),
    .AW           (AW)
  ) u_porta_b (
    .clk             (clk),
    .rst             (rst),
    .ativo           (ativo),
    .leitura         (leitura_b),
    .reg_num         (reg_b),
    .dado_armazenado (registrador_q[idx_b]),
    .escrita_efetiva (escrita_efetiva),
    .reg_escrita     (reg_escrita),
    .dado_escrito    (dado_escrito),
    .dado_lido       (dado_lido_b),
    .valido          (valido_b)
  );

endmodule

// File: tb/tb_banco_de_registradores_2l1e.sv
// Directed bench: default bank, a ZERO_FIXO=0 bank and a 6-deep bank share stimulus.
module tb_banco_de_registradores_2l1e;

  localparam int W  = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          escrita;
  logic [AW-1:0] reg_escrita;
  logic [W-1:0]  dado_escrito;
  logic          leitura_a, leitura_b;
  logic [AW-1:0] reg_a, reg_b;

  logic [W-1:0] d_a, d_b, z_a, z_b, p_a, p_b;
  logic         v_a, v_b, zv_a, zv_b, pv_a, pv_b;
  logic         ocp, z_ocp, p_ocp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  banco_de_registradores_2l1e #(.LARGURA(W), .PROFUNDIDADE(8), .ZERO_FIXO(1)) dut (
    .clk(clk), .rst(rst), .escrita(escrita), .reg_escrita(reg_escrita),
    .dado_escrito(dado_escrito), .leitura_a(leitura_a), .reg_a(reg_a),
    .dado_lido_a(d_a), .valido_a(v_a), .leitura_b(leitura_b), .reg_b(reg_b),
    .dado_lido_b(d_b), .valido_b(v_b), .ocupado(ocp)
  );

  banco_de_registradores_2l1e #(.LARGURA(W), .PROFUNDIDADE(8), .ZERO_FIXO(0)) dut_z0 (
    .clk(clk), .rst(rst), .escrita(escrita), .reg_escrita(reg_escrita),
    .dado_escrito(dado_escrito), .leitura_a(leitura_a), .reg_a(reg_a),
    .dado_lido_a(z_a), .valido_a(zv_a), .leitura_b(leitura_b), .reg_b(reg_b),
    .dado_lido_b(z_b), .valido_b(zv_b), .ocupado(z_ocp)
  );

  banco_de_registradores_2l1e #(.LARGURA(W), .PROFUNDIDADE(6), .ZERO_FIXO(1)) dut_p6 (
    .clk(clk), .rst(rst), .escrita(escrita), .reg_escrita(reg_escrita),
    .dado_escrito(dado_escrito), .leitura_a(leitura_a), .reg_a(reg_a),
    .dado_lido_a(p_a), .valido_a(pv_a), .leitura_b(leitura_b), .reg_b(reg_b),
    .dado_lido_b(p_b), .valido_b(pv_b), .ocupado(p_ocp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    escrita   = 1'b0;
    leitura_a = 1'b0;
    leitura_b = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    idle();
    reg_escrita = '0; dado_escrito = '0; reg_a = '0; reg_b = '0;
    step();
    n_checks++;
    if (ocp !== 1'b1 || d_a !== '0 || d_b !== '0 || v_a !== 1'b0 || v_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ocupado=%b a=%0h b=%0h va=%b vb=%b, want 1 0 0 0 0",
               ocp, d_a, d_b, v_a, v_b);
    end
    rst = 1'b0;
    n = 0;
    while (ocp === 1'b1 && n < 20) begin
      step();
      n++;
    end
    n_checks++;
    if (n != 8) begin
      n_fail++;
      $display("FAIL ocupado_len: %0d cycles, want 8", n);
    end
    n_checks++;
    if (z_ocp !== 1'b0 || p_ocp !== 1'b0) begin
      n_fail++;
      $display("FAIL ocupado_others: z0=%b p6=%b, want 0 0", z_ocp, p_ocp);
    end
    for (int r = 0; r < 8; r++) begin
      leitura_a = 1'b1;
      reg_a     = AW'(r);
      step();
      n_checks++;
      if (v_a !== 1'b1 || d_a !== '0 || z_a !== '0) begin
        n_fail++;
        $display("FAIL clear_read r%0d: v=%b d=%0h z0=%0h, want 1 0 0", r, v_a, d_a, z_a);
      end
      leitura_a = 1'b0;
      step();
      n_checks++;
      if (v_a !== 1'b0) begin
        n_fail++;
        $display("FAIL valid_pulse r%0d: v=%b, want 0", r, v_a);
      end
    end
  endtask

  task automatic test_write_read();
    escrita = 1'b1; reg_escrita = 3'd3; dado_escrito = 32'd1001;
    step();
    escrita = 1'b0;
    leitura_a = 1'b1; reg_a = 3'd3;
    leitura_b = 1'b1; reg_b = 3'd7;
    step();
    n_checks++;
    if (d_a !== 32'd1001 || v_a !== 1'b1) begin
      n_fail++;
      $display("FAIL read_r3: d=%0d v=%b, want 1001 1", d_a, v_a);
    end
    n_checks++;
    if (d_b !== 32'd0 || v_b !== 1'b1) begin
      n_fail++;
      $display("FAIL read_r7_b: d=%0d v=%b, want 0 1", d_b, v_b);
    end
    idle();
    step();
    n_checks++;
    if (d_a !== 32'd1001 || v_a !== 1'b0 || v_b !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_a: d=%0d va=%b vb=%b, want 1001 0 0", d_a, v_a, v_b);
    end
  endtask

  task automatic test_back_to_back();
    escrita = 1'b1; reg_escrita = 3'd5; dado_escrito = 32'd511;
    leitura_a = 1'b1; reg_a = 3'd5;
    leitura_b = 1'b1; reg_b = 3'd5;
    step();
    n_checks++;
    if (d_a !== 32'd511 || d_b !== 32'd511 || v_a !== 1'b1 || v_b !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_r5: a=%0d b=%0d va=%b vb=%b, want 511 511 1 1", d_a, d_b, v_a, v_b);
    end
    idle();
    step();
    leitura_a = 1'b1; reg_a = 3'd5;
    step();
    n_checks++;
    if (d_a !== 32'd511 || v_a !== 1'b1) begin
      n_fail++;
      $display("FAIL stored_r5: d=%0d v=%b, want 511 1", d_a, v_a);
    end
    idle();
  endtask

  task automatic test_zero_fixo();
    escrita = 1'b1; reg_escrita = 3'd0; dado_escrito = 32'd999;
    step();
    escrita = 1'b0;
    leitura_a = 1'b1; reg_a = 3'd0;
    step();
    n_checks++;
    if (d_a !== 32'd0 || p_a !== 32'd0) begin
      n_fail++;
      $display("FAIL zero_r0: zf1=%0d p6=%0d, want 0 0", d_a, p_a);
    end
    n_checks++;
    if (z_a !== 32'd999 || zv_a !== 1'b1) begin
      n_fail++;
      $display("FAIL plain_r0: d=%0d v=%b, want 999 1", z_a, zv_a);
    end
    idle();
    step();
  endtask

  task automatic test_depth6();
    escrita = 1'b1; reg_escrita = 3'd7; dado_escrito = 32'd77;
    step();
    escrita = 1'b0;
    leitura_a = 1'b1; reg_a = 3'd7;
    step();
    n_checks++;
    if (p_a !== 32'd0 || pv_a !== 1'b1) begin
      n_fail++;
      $display("FAIL p6_r7: d=%0d v=%b, want 0 1", p_a, pv_a);
    end
    n_checks++;
    if (d_a !== 32'd77) begin
      n_fail++;
      $display("FAIL p8_r7: d=%0d, want 77", d_a);
    end
    idle();
    escrita = 1'b1; reg_escrita = 3'd5; dado_escrito = 32'd131;
    step();
    escrita = 1'b0;
    leitura_a = 1'b1; reg_a = 3'd5;
    step();
    n_checks++;
    if (p_a !== 32'd131) begin
      n_fail++;
      $display("FAIL p6_r5: d=%0d, want 131", p_a);
    end
    idle();
    step();
  endtask

  task automatic test_reset_mid_clear();
    int n;
    escrita = 1'b1; reg_escrita = 3'd2; dado_escrito = 32'd42;
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    escrita = 1'b1; reg_escrita = 3'd2; dado_escrito = 32'd55;
    leitura_a = 1'b1; reg_a = 3'd2;
    leitura_b = 1'b1; reg_b = 3'd3;
    n = 0;
    while (ocp === 1'b1 && n < 20) begin
      step();
      n++;
      n_checks++;
      if (v_a !== 1'b0 || v_b !== 1'b0 || d_a !== '0 || d_b !== '0) begin
        n_fail++;
        $display("FAIL busy_ignore c%0d: va=%b vb=%b a=%0h b=%0h, want 0 0 0 0",
                 n, v_a, v_b, d_a, d_b);
      end
    end
    idle();
    n_checks++;
    if (n != 8) begin
      n_fail++;
      $display("FAIL restart_len: %0d cycles, want 8", n);
    end
    leitura_a = 1'b1; reg_a = 3'd2;
    step();
    n_checks++;
    if (d_a !== 32'd0 || v_a !== 1'b1) begin
      n_fail++;
      $display("FAIL r2_cleared: d=%0d v=%b, want 0 1", d_a, v_a);
    end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_zero_fixo();
    test_depth6();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
